// File: rtl/tcdm_bank_responder_pkg.sv
// rtl/tcdm_bank_responder_pkg.sv - shared types and helpers for the TCDM bank responder
package tcdm_bank_responder_pkg;

    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_e;

    // LR/SC and unknown codes are not read-modify-write; they degrade to a plain read.
    function automatic logic amo_is_rmw(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'h9);
    endfunction

    function automatic int unsigned constant_bits_lsb(input int unsigned byte_offset,
                                                      input int unsigned num_banks);
        return byte_offset + $clog2(num_banks);
    endfunction

endpackage

// File: rtl/tcdm_amo_alu.sv
// rtl/tcdm_amo_alu.sv - combinational AMO new-value computation
module tcdm_amo_alu
    import tcdm_bank_responder_pkg::*;
#(
    parameter int unsigned DataWidth = 32
) (
    input  logic [3:0]           amo_i,
    input  logic [DataWidth-1:0] old_i,
    input  logic [DataWidth-1:0] operand_i,
    output logic [DataWidth-1:0] result_o
);

    always_comb begin
        result_o = old_i;
        case (amo_op_e'(amo_i))
            AMOSwap: result_o = operand_i;
            AMOAdd:  result_o = old_i + operand_i;
            AMOAnd:  result_o = old_i & operand_i;
            AMOOr:   result_o = old_i | operand_i;
            AMOXor:  result_o = old_i ^ operand_i;
            AMOMax:  result_o = ($signed(old_i) > $signed(operand_i)) ? old_i : operand_i;
            AMOMaxu: result_o = (old_i > operand_i) ? old_i : operand_i;
            AMOMin:  result_o = ($signed(old_i) < $signed(operand_i)) ? old_i : operand_i;
            AMOMinu: result_o = (old_i < operand_i) ? old_i : operand_i;
            default: result_o = old_i;
        endcase
    end

endmodule

// File: rtl/tcdm_bank_responder_resp_fifo.sv
// rtl/tcdm_bank_responder_resp_fifo.sv - fall-through response queue
module tcdm_bank_responder_resp_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             empty, do_write, do_read;

    assign empty    = (count_q == '0);
    assign valid_o  = !empty || push_i;
    assign data_o   = empty ? data_i : mem_q[rd_ptr_q];
    assign do_read  = pop_i && !empty;
    // A push into an empty queue that is popped in the same cycle bypasses storage.
    assign do_write = push_i && !(empty && pop_i);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_write) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (do_read) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        if (do_write && !do_read) begin
            count_d = count_q + CntW'(1);
        end else if (!do_write && do_read) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/tcdm_bank_responder.sv
// rtl/tcdm_bank_responder.sv - TCDM request terminator driving one SRAM bank, with local AMOs
module tcdm_bank_responder
    import tcdm_bank_responder_pkg::*;
#(
    parameter int unsigned DataWidth       = 32,
    parameter int unsigned AddrWidth       = 32,
    parameter int unsigned MetaIdWidth     = 3,
    parameter int unsigned ByteOffset      = 2,
    parameter int unsigned NumBanksPerTile = 16,
    parameter int unsigned BankAddrWidth   = 10,
    parameter int unsigned RespDepth       = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     tcdm_req_valid_i,
    input  logic [AddrWidth-1:0]     tcdm_req_tgt_addr_i,
    input  logic                     tcdm_req_wen_i,
    input  logic [DataWidth-1:0]     tcdm_req_wdata_i,
    input  logic [3:0]               tcdm_req_amo_i,
    input  logic [MetaIdWidth-1:0]   tcdm_req_id_i,
    input  logic [DataWidth/8-1:0]   tcdm_req_be_i,
    output logic                     tcdm_req_ready_o,
    output logic                     tcdm_resp_valid_o,
    input  logic                     tcdm_resp_ready_i,
    output logic [DataWidth-1:0]     tcdm_resp_rdata_o,
    output logic [MetaIdWidth-1:0]   tcdm_resp_id_o,
    output logic                     tcdm_resp_wen_o,
    output logic                     sram_req_o,
    output logic                     sram_we_o,
    output logic [BankAddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0]     sram_wdata_o,
    output logic [DataWidth/8-1:0]   sram_be_o,
    input  logic [DataWidth-1:0]     sram_rdata_i
);

    localparam int unsigned StrbWidth       = DataWidth / 8;
    localparam int unsigned ConstantBitsLSB = constant_bits_lsb(ByteOffset, NumBanksPerTile);
    localparam int unsigned CntWidth        = $clog2(RespDepth + 1);
    localparam int unsigned RespWidth       = DataWidth + MetaIdWidth + 1;
    localparam logic [0:0]  StIdle          = 1'b0;
    localparam logic [0:0]  StAmoWr         = 1'b1;

    if (DataWidth != 32) begin : g_bad_data_width
        $fatal(1, "tcdm_bank_responder: only DataWidth=32 is supported");
    end
    if (RespDepth < 2) begin : g_bad_resp_depth
        $fatal(1, "tcdm_bank_responder: RespDepth must be at least 2");
    end

    logic [0:0]               state_q, state_d;
    logic [CntWidth-1:0]      cnt_q, cnt_d;
    logic                     pend_q, pend_d;
    logic                     pend_wen_q, pend_wen_d;
    logic [MetaIdWidth-1:0]   pend_id_q, pend_id_d;
    logic [3:0]               amo_op_q, amo_op_d;
    logic [DataWidth-1:0]     amo_operand_q, amo_operand_d;
    logic [BankAddrWidth-1:0] amo_addr_q, amo_addr_d;
    logic [MetaIdWidth-1:0]   amo_id_q, amo_id_d;

    logic                     req_accept, req_is_amo, resp_pop, push;
    logic [BankAddrWidth-1:0] req_bank_addr;
    logic [DataWidth-1:0]     amo_result;
    logic [RespWidth-1:0]     push_data, pop_data;
    logic                     unused_addr_bits;

    assign req_bank_addr    = tcdm_req_tgt_addr_i[ConstantBitsLSB +: BankAddrWidth];
    assign unused_addr_bits = ^{tcdm_req_tgt_addr_i[AddrWidth-1:ConstantBitsLSB+BankAddrWidth],
                                tcdm_req_tgt_addr_i[ConstantBitsLSB-1:0]};

    // Credits cover in-flight SRAM results too, so the queue can never overflow.
    assign tcdm_req_ready_o = !rst_i && (state_q == StIdle) && (cnt_q < CntWidth'(RespDepth));
    assign req_accept       = tcdm_req_valid_i && tcdm_req_ready_o;
    assign req_is_amo       = !tcdm_req_wen_i && amo_is_rmw(tcdm_req_amo_i);
    assign resp_pop         = tcdm_resp_valid_o && tcdm_resp_ready_i;

    tcdm_amo_alu #(
        .DataWidth (DataWidth)
    ) i_amo_alu (
        .amo_i     (amo_op_q),
        .old_i     (sram_rdata_i),
        .operand_i (amo_operand_q),
        .result_o  (amo_result)
    );

    always_comb begin
        state_d       = state_q;
        pend_d        = 1'b0;
        pend_wen_d    = pend_wen_q;
        pend_id_d     = pend_id_q;
        amo_op_d      = amo_op_q;
        amo_operand_d = amo_operand_q;
        amo_addr_d    = amo_addr_q;
        amo_id_d      = amo_id_q;
        sram_req_o    = 1'b0;
        sram_we_o     = 1'b0;
        sram_addr_o   = req_bank_addr;
        sram_wdata_o  = tcdm_req_wdata_i;
        sram_be_o     = tcdm_req_be_i;
        push          = pend_q;
        push_data     = {pend_wen_q ? {DataWidth{1'b0}} : sram_rdata_i, pend_id_q, pend_wen_q};

        // AMO_WR is only entered from an AMO accept, so no plain response is pending then.
        if (state_q == StAmoWr) begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = amo_addr_q;
            sram_wdata_o = amo_result;
            sram_be_o    = {StrbWidth{1'b1}};
            push         = 1'b1;
            push_data    = {sram_rdata_i, amo_id_q, 1'b0};
            state_d      = StIdle;
        end

        if (req_accept) begin
            sram_req_o = 1'b1;
            sram_we_o  = tcdm_req_wen_i;
            if (req_is_amo) begin
                state_d       = StAmoWr;
                amo_op_d      = tcdm_req_amo_i;
                amo_operand_d = tcdm_req_wdata_i;
                amo_addr_d    = req_bank_addr;
                amo_id_d      = tcdm_req_id_i;
            end else begin
                pend_d     = 1'b1;
                pend_wen_d = tcdm_req_wen_i;
                pend_id_d  = tcdm_req_id_i;
            end
        end

        cnt_d = cnt_q;
        if (req_accept && !resp_pop) begin
            cnt_d = cnt_q + CntWidth'(1);
        end else if (!req_accept && resp_pop) begin
            cnt_d = cnt_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            pend_q        <= 1'b0;
            pend_wen_q    <= 1'b0;
            pend_id_q     <= '0;
            amo_op_q      <= '0;
            amo_operand_q <= '0;
            amo_addr_q    <= '0;
            amo_id_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            pend_wen_q    <= pend_wen_d;
            pend_id_q     <= pend_id_d;
            amo_op_q      <= amo_op_d;
            amo_operand_q <= amo_operand_d;
            amo_addr_q    <= amo_addr_d;
            amo_id_q      <= amo_id_d;
        end
    end

    tcdm_bank_responder_resp_fifo #(
        .Width (RespWidth),
        .Depth (RespDepth)
    ) i_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (resp_pop),
        .valid_o (tcdm_resp_valid_o),
        .data_o  (pop_data)
    );

    assign {tcdm_resp_rdata_o, tcdm_resp_id_o, tcdm_resp_wen_o} = pop_data;

endmodule
